// File: rtl/alu_operand_stage_if.sv
// Bundle between decode/MEM/WB and the EX operand stage. The master modport is the pipeline
// side that feeds decode and bypass values; the slave modport is the operand stage itself.
interface alu_operand_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    // decode -> EX
    logic              id_valid;
    logic              stall;
    logic              flush;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic [3:0]        id_alu_ctrl;
    logic              id_src_a_pc;
    logic              id_src_b_imm;
    logic              id_reg_write;
    logic              id_mem_read;

    // bypass sources from later stages
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic              mem_reg_write;
    logic              wb_reg_write;
    logic [XLEN-1:0]   mem_result;
    logic [XLEN-1:0]   wb_result;

    // EX -> ALU / hazard unit
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [3:0]        alu_ctrl;
    logic [XLEN-1:0]   ex_store_data;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              load_use_stall;

    modport master (
        output id_valid, stall, flush, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_ctrl, id_src_a_pc, id_src_b_imm,
               id_reg_write, id_mem_read,
               mem_rd, wb_rd, mem_reg_write, wb_reg_write, mem_result, wb_result,
        input  alu_a, alu_b, alu_ctrl, ex_store_data, ex_valid, ex_rd,
               ex_reg_write, ex_mem_read, load_use_stall
    );

    modport slave (
        input  id_valid, stall, flush, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_ctrl, id_src_a_pc, id_src_b_imm,
               id_reg_write, id_mem_read,
               mem_rd, wb_rd, mem_reg_write, wb_reg_write, mem_result, wb_result,
        output alu_a, alu_b, alu_ctrl, ex_store_data, ex_valid, ex_rd,
               ex_reg_write, ex_mem_read, load_use_stall
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use hazard detection.
// Build option: define ALU_FWD_EN to enable forwarding; otherwise hazards are resolved by stalling.
module alu_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               reset,
    alu_operand_stage_if.slave bus
);
    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
`ifdef ALU_FWD_EN
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
`endif
        logic [REG_AW-1:0] rd;
        logic [3:0]        alu_ctrl;
        logic              src_a_pc;
        logic              src_b_imm;
        logic              reg_write;
        logic              mem_read;
    } ex_reg_t;

    ex_reg_t ex_q;

    // A flush always wins over stall; an invalid decode slot loads a bubble only when not stalled.
    logic load_bubble;
    assign load_bubble = bus.flush || (!bus.stall && !bus.id_valid);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= '0;
            ex_q.alu_ctrl <= ALU_ADD;
        end else if (load_bubble) begin
            ex_q.valid     <= 1'b0;
            ex_q.reg_write <= 1'b0;
            ex_q.mem_read  <= 1'b0;
            ex_q.alu_ctrl  <= ALU_ADD;
        end else if (!bus.stall) begin
            ex_q.valid     <= 1'b1;
            ex_q.pc        <= bus.id_pc;
            ex_q.rs1_data  <= bus.id_rs1_data;
            ex_q.rs2_data  <= bus.id_rs2_data;
            ex_q.imm       <= bus.id_imm;
`ifdef ALU_FWD_EN
            ex_q.rs1       <= bus.id_rs1;
            ex_q.rs2       <= bus.id_rs2;
`endif
            ex_q.rd        <= bus.id_rd;
            ex_q.alu_ctrl  <= bus.id_alu_ctrl;
            ex_q.src_a_pc  <= bus.id_src_a_pc;
            ex_q.src_b_imm <= bus.id_src_b_imm;
            ex_q.reg_write <= bus.id_reg_write;
            ex_q.mem_read  <= bus.id_mem_read;
        end
    end

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // A load in EX whose result a decoded source needs cannot be bypassed in time.
    logic ex_load_hit;
    assign ex_load_hit = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0)
                         && ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));

`ifdef ALU_FWD_EN
    logic mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;
    assign mem_hit_rs1 = bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == ex_q.rs1);
    assign mem_hit_rs2 = bus.mem_reg_write && (bus.mem_rd != '0) && (bus.mem_rd == ex_q.rs2);
    assign wb_hit_rs1  = bus.wb_reg_write  && (bus.wb_rd  != '0) && (bus.wb_rd  == ex_q.rs1);
    assign wb_hit_rs2  = bus.wb_reg_write  && (bus.wb_rd  != '0) && (bus.wb_rd  == ex_q.rs2);

    // NOTE: each always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        fwd_rs1 = ex_q.rs1_data;
        fwd_rs2 = ex_q.rs2_data;
        // MEM holds the younger result, so it is tested before WB.
        if (mem_hit_rs1)      fwd_rs1 = bus.mem_result;
        else if (wb_hit_rs1)  fwd_rs1 = bus.wb_result;
        if (mem_hit_rs2)      fwd_rs2 = bus.mem_result;
        else if (wb_hit_rs2)  fwd_rs2 = bus.wb_result;
    end

    assign bus.load_use_stall = bus.id_valid && ex_load_hit;
`else
    assign fwd_rs1 = ex_q.rs1_data;
    assign fwd_rs2 = ex_q.rs2_data;

    // Without bypass paths, any pending write to a nonzero source in EX or MEM must stall decode.
    function automatic logic raw_hit(
        input logic [REG_AW-1:0] src,
        input logic              ex_w,
        input logic [REG_AW-1:0] ex_dst,
        input logic              mem_w,
        input logic [REG_AW-1:0] mem_dst
    );
        return (src != '0) && ((ex_w && (ex_dst == src)) || (mem_w && (mem_dst == src)));
    endfunction

    logic ex_writes;
    assign ex_writes = ex_q.valid && ex_q.reg_write;

    assign bus.load_use_stall = bus.id_valid
        && (ex_load_hit
            || raw_hit(bus.id_rs1, ex_writes, ex_q.rd, bus.mem_reg_write, bus.mem_rd)
            || raw_hit(bus.id_rs2, ex_writes, ex_q.rd, bus.mem_reg_write, bus.mem_rd));
`endif

    assign bus.alu_a         = ex_q.src_a_pc  ? ex_q.pc  : fwd_rs1;
    assign bus.alu_b         = ex_q.src_b_imm ? ex_q.imm : fwd_rs2;
    assign bus.alu_ctrl      = ex_q.alu_ctrl;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_reg_write  = ex_q.valid && ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.valid && ex_q.mem_read;
endmodule
